// File: rtl/led_pkg.sv
// Shared constants, FSM state type and frame-layout helper for the LED
// matrix frame controller.
package led_pkg;

  localparam int ROWS      = 16;
  localparam int COLS      = 16;
  localparam int ROW_IDX_W = 4;

  // Frame-store sequencer states. The encoding is visible on the debug port.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    WAIT_SWAP = 2'd2,
    COPY      = 2'd3
  } fsm_state_t;

  // Bit offset of row k inside the flat 256-bit display bus.
  function automatic int unsigned row_slice(input int unsigned k);
    return k * COLS;
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Row-slot prescaler and row scanner. Free-running, independent of the
// frame-store FSM; only reset restarts it.
module led_scan_timer
  import led_pkg::*;
#(
  parameter int SCAN_DIV = 3125
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 scan_tick,
  output logic [ROW_IDX_W-1:0] scan_row,
  output logic                 frame_start
);

  // A one-bit counter is the smallest legal case (SCAN_DIV == 2).
  localparam int                   CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ROW_IDX_W-1:0] row_q, row_d;
  logic                 tick;

  // Tick on the last count of a slot; the row advances on the following cycle.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    row_d = tick ? row_q + ROW_IDX_W'(1) : row_q;
  end

  // Prescaler and row registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

  assign scan_tick   = tick;
  assign scan_row    = row_q;
  assign frame_start = tick && (row_q == LAST_ROW);

endmodule

// File: rtl/led_frame_ctrl.sv
// Double-buffered 16x16 LED frame store. The writer fills the back buffer
// through a req/ack handshake and commits; the swap is deferred to the next
// frame boundary so a scan never shows half of two frames. After the swap
// the new front is copied into the new back so the writer can make
// incremental edits.
//
// Write handshake: wr_req is held with wr_row/wr_data stable until wr_ack.
// A request is taken in IDLE when wr_ack was low the previous cycle; the row
// is stored at that posedge and wr_ack pulses for exactly one cycle after.
// While busy (any state other than IDLE) requests are left pending and never
// acknowledged.
module led_frame_ctrl
  import led_pkg::*;
#(
  parameter int SCAN_DIV = 3125
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_req,
  input  logic [ROW_IDX_W-1:0] wr_row,
  input  logic [COLS-1:0]      wr_data,
  output logic                 wr_ack,
  input  logic                 commit,
  input  logic                 clear,
  output logic                 busy,
  output logic                 scan_tick,
  output logic [ROW_IDX_W-1:0] scan_row,
  output logic                 frame_start,
  output logic [ROWS*COLS-1:0] disp_frame,
  output logic [1:0]           dbg_state
);

  fsm_state_t           state_q, state_d;
  logic [ROW_IDX_W-1:0] idx_q, idx_d;
  logic                 front_sel_q, front_sel_d;
  logic                 ack_q, ack_d;
  logic                 back_sel;

  // buf_q[b][r] is row r of buffer b; packed rows match the display layout.
  logic [1:0][ROWS-1:0][COLS-1:0] buf_q;

  logic                 wr_en;
  logic [ROW_IDX_W-1:0] wr_idx;
  logic [COLS-1:0]      wr_word;

  logic [ROWS*COLS-1:0] disp_q, disp_d;

  localparam logic [ROW_IDX_W-1:0] LAST_IDX = ROW_IDX_W'(ROWS - 1);

  led_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_tick   (scan_tick),
    .scan_row    (scan_row),
    .frame_start (frame_start)
  );

  assign back_sel = ~front_sel_q;

  // Next-state logic and the single back-buffer write port it steers.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    front_sel_d = front_sel_q;
    ack_d       = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = wr_row;
    wr_word     = wr_data;

    case (state_q)
      IDLE: begin
        // clear beats commit beats a pending write.
        if (clear) begin
          state_d = CLEAR;
          idx_d   = '0;
        end else if (commit) begin
          state_d = WAIT_SWAP;
        end else if (wr_req && !ack_q) begin
          wr_en = 1'b1;
          ack_d = 1'b1;
        end
      end

      CLEAR: begin
        wr_en   = 1'b1;
        wr_idx  = idx_q;
        wr_word = '0;
        idx_d   = idx_q + ROW_IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end

      WAIT_SWAP: begin
        // Only a boundary seen while already waiting triggers the swap.
        if (frame_start) begin
          front_sel_d = ~front_sel_q;
          idx_d       = '0;
          state_d     = COPY;
        end
      end

      COPY: begin
        // front_sel_q already points at the new front here.
        wr_en   = 1'b1;
        wr_idx  = idx_q;
        wr_word = buf_q[front_sel_q][idx_q];
        idx_d   = idx_q + ROW_IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Display image follows the front selection that is about to be latched,
  // so the new frame appears on the cycle right after the swap.
  for (genvar k = 0; k < ROWS; k++) begin : g_disp
    assign disp_d[row_slice(k) +: COLS] = buf_q[front_sel_d][k];
  end

  // Control registers: state, row index, front selection, ack and display.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      front_sel_q <= 1'b0;
      ack_q       <= 1'b0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      front_sel_q <= front_sel_d;
      ack_q       <= ack_d;
      disp_q      <= disp_d;
    end
  end

  // Frame buffers; the front buffer is never written, only the back one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (wr_en) begin
      buf_q[back_sel][wr_idx] <= wr_word;
    end
  end

  assign wr_ack     = ack_q;
  assign busy       = (state_q != IDLE);
  assign disp_frame = disp_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Directed bench for led_frame_ctrl with a short row slot (SCAN_DIV=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_frame_ctrl;

  localparam int SCAN_DIV = 4;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_CLEAR     = 2'd1;
  localparam logic [1:0] S_WAIT_SWAP = 2'd2;
  localparam logic [1:0] S_COPY      = 2'd3;

  // Hand-built frames: row k occupies bits [16k+15:16k].
  localparam logic [255:0] F_ZERO = 256'h0;
  localparam logic [255:0] F2 = (256'(16'hA5A5) << 48) | 256'(16'hC003);
  localparam logic [255:0] F3 = (256'(16'h0001) << 48) | 256'(16'hC003);
  localparam logic [255:0] F4 = (256'(16'h8001) << 96);
  localparam logic [255:0] F5 = (256'(16'h8001) << 96) | (256'(16'hBEEF) << 192);

  logic         clk;
  logic         rst_n;
  logic         wr_req;
  logic [3:0]   wr_row;
  logic [15:0]  wr_data;
  logic         wr_ack;
  logic         commit;
  logic         clear;
  logic         busy;
  logic         scan_tick;
  logic [3:0]   scan_row;
  logic         frame_start;
  logic [255:0] disp_frame;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [255:0] exp_q[$];
  logic [255:0] shown_f;

  led_frame_ctrl #(
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .commit      (commit),
    .clear       (clear),
    .busy        (busy),
    .scan_tick   (scan_tick),
    .scan_row    (scan_row),
    .frame_start (frame_start),
    .disp_frame  (disp_frame),
    .dbg_state   (dbg_state)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Bounded wait for the frame boundary pulse.
  task automatic wait_frame_start(input string tag);
    int n;
    n = 0;
    while (!frame_start && n < 80) begin
      step();
      n++;
    end
    check({tag, "_frame_start_seen"}, 256'(frame_start), 256'(1'b1));
  endtask

  task automatic write_row(input logic [3:0] r, input logic [15:0] d);
    wr_req  = 1'b1;
    wr_row  = r;
    wr_data = d;
    step();
    check("wr_ack_pulse", 256'(wr_ack), 256'(1'b1));
    wr_req = 1'b0;
    step();
    check("wr_ack_one_cycle", 256'(wr_ack), 256'(1'b0));
  endtask

  // Commit, wait for the swap and walk the copy phase; the new frame comes
  // from the expected queue.
  task automatic commit_and_swap(input string tag);
    logic [255:0] new_f;
    new_f = '0;
    check({tag, "_exp_q_nonempty"}, 256'(exp_q.size() > 0), 256'(1'b1));
    if (exp_q.size() > 0) new_f = exp_q.pop_front();
    commit = 1'b1;
    step();
    commit = 1'b0;
    check({tag, "_state_wait"}, 256'(dbg_state), 256'(S_WAIT_SWAP));
    check({tag, "_busy_wait"}, 256'(busy), 256'(1'b1));
    wait_frame_start(tag);
    check({tag, "_disp_before_swap"}, disp_frame, shown_f);
    step();
    check({tag, "_disp_after_swap"}, disp_frame, new_f);
    check({tag, "_state_copy"}, 256'(dbg_state), 256'(S_COPY));
    repeat (15) step();
    check({tag, "_busy_last_copy"}, 256'(busy), 256'(1'b1));
    step();
    check({tag, "_busy_low"}, 256'(busy), 256'(1'b0));
    check({tag, "_disp_settled"}, disp_frame, new_f);
    shown_f = new_f;
  endtask

  initial begin
    int acks_seen;
    int n;

    rst_n   = 1'b0;
    wr_req  = 1'b0;
    wr_row  = '0;
    wr_data = '0;
    commit  = 1'b0;
    clear   = 1'b0;
    shown_f = F_ZERO;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state.
    check("rst_state", 256'(dbg_state), 256'(S_IDLE));
    check("rst_busy", 256'(busy), 256'(1'b0));
    check("rst_wr_ack", 256'(wr_ack), 256'(1'b0));
    check("rst_disp", disp_frame, F_ZERO);

    // Test 1: scan timing while idle.
    for (int i = 0; i < 68; i++) begin
      check("scan_tick", 256'(scan_tick), 256'(i % 4 == 3));
      check("scan_row", 256'(scan_row), 256'((i / 4) % 16));
      check("frame_start", 256'(frame_start), 256'(i % 64 == 63));
      step();
    end
    check("idle_disp", disp_frame, F_ZERO);

    // Test 2: first frame.
    write_row(4'd3, 16'hA5A5);
    write_row(4'd0, 16'hC003);
    exp_q.push_back(F2);
    commit_and_swap("t2");

    // Test 3: incremental edit on the pre-copied back buffer.
    write_row(4'd3, 16'h0001);
    exp_q.push_back(F3);
    commit_and_swap("t3");

    // Test 4: clear wins over commit; a commit during CLEAR is ignored.
    write_row(4'd5, 16'hFFFF);
    clear  = 1'b1;
    commit = 1'b1;
    step();
    clear  = 1'b0;
    commit = 1'b0;
    check("t4_state_clear", 256'(dbg_state), 256'(S_CLEAR));
    step();
    step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    repeat (12) step();
    check("t4_clear_last", 256'(dbg_state), 256'(S_CLEAR));
    step();
    check("t4_back_idle", 256'(dbg_state), 256'(S_IDLE));
    check("t4_no_swap", disp_frame, F3);
    write_row(4'd6, 16'h8001);
    exp_q.push_back(F4);
    commit_and_swap("t4");
    check("t4_row5_zero", 256'(disp_frame[95:80]), 256'(16'h0000));

    // Test 5: write held across commit and WAIT_SWAP/COPY.
    commit  = 1'b1;
    wr_req  = 1'b1;
    wr_row  = 4'd12;
    wr_data = 16'hBEEF;
    step();
    commit = 1'b0;
    check("t5_state_wait", 256'(dbg_state), 256'(S_WAIT_SWAP));
    acks_seen = 0;
    n = 0;
    while (busy && n < 200) begin
      if (wr_ack) acks_seen++;
      step();
      n++;
    end
    check("t5_busy_fell", 256'(busy), 256'(1'b0));
    check("t5_no_ack_while_busy", 256'(acks_seen), 256'(0));
    check("t5_no_ack_at_idle", 256'(wr_ack), 256'(1'b0));
    check("t5_disp_same_frame", disp_frame, F4);
    step();
    check("t5_ack", 256'(wr_ack), 256'(1'b1));
    wr_req = 1'b0;
    step();
    check("t5_ack_once", 256'(wr_ack), 256'(1'b0));
    exp_q.push_back(F5);
    commit_and_swap("t5");

    // Test 6: reset in the middle of COPY (row 7).
    commit = 1'b1;
    step();
    commit = 1'b0;
    wait_frame_start("t6");
    step();
    repeat (7) step();
    check("t6_in_copy", 256'(dbg_state), 256'(S_COPY));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_state", 256'(dbg_state), 256'(S_IDLE));
    check("t6_busy", 256'(busy), 256'(1'b0));
    check("t6_disp", disp_frame, F_ZERO);
    check("t6_scan_row", 256'(scan_row), 256'(0));
    check("t6_scan_tick", 256'(scan_tick), 256'(1'b0));
    check("t6_wr_ack", 256'(wr_ack), 256'(1'b0));
    step();
    step();
    check("t6_tick_cnt2", 256'(scan_tick), 256'(1'b0));
    step();
    check("t6_tick_cnt3", 256'(scan_tick), 256'(1'b1));
    step();
    check("t6_row_adv", 256'(scan_row), 256'(1));
    shown_f = F_ZERO;
    exp_q.push_back(F_ZERO);
    commit_and_swap("t6_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_frame_ctrl.md
Name: led_frame_ctrl

Overview:
Double-buffered frame-store and scan sequencer for the 16x16 LED matrix. Game logic writes row words into a back buffer over a req/ack handshake, then commits the frame. The block swaps buffers only on a scan-frame boundary, so the display never tears. It presents the front buffer as a flat 256-bit bus plus a row-slot tick to the matrix row driver.

Parameters:
SCAN_DIV, 3125, clk cycles per row slot (50 MHz / 16 rows / 1 kHz frame); legal range >= 2
ROWS, 16, matrix rows; localparam, not overridable
COLS, 16, matrix columns / row word width; localparam, not overridable

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
wr_req  input  1  row write request; hold until wr_ack
wr_row  input  4  target row index in back buffer, 0..15
wr_data  input  16  row word; bit c = column c lit
wr_ack  output  1  one-cycle pulse; the write has been stored
commit  input  1  one-cycle pulse; back buffer complete, request swap
clear  input  1  one-cycle pulse; zero the back buffer
busy  output  1  high in CLEAR, WAIT_SWAP and COPY; writes stall
scan_tick  output  1  one-cycle pulse at the end of each row slot
scan_row  output  4  current scanned row, 0..15
frame_start  output  1  pulse coincident with the scan_tick that wraps scan_row 15->0
disp_frame  output  256  front buffer; row k at bits [16k+15:16k]

Behaviour:
- Reset (rst_n=0 at posedge) state:
  - Both buffers are zero and front_sel=0.
  - Prescaler=0, scan_row=0, state=IDLE.
  - wr_ack, busy, scan_tick, frame_start and disp_frame are all 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps; width is $clog2(SCAN_DIV).
  - scan_tick=1 for the cycle where the count equals SCAN_DIV-1.
  - scan_row increments on the cycle after a tick and wraps 15->0.
  - frame_start=scan_tick && scan_row==15.
  - The scan logic runs independently of the FSM.
- FSM states: IDLE, CLEAR, WAIT_SWAP, COPY.
- IDLE:
  - If wr_req is high and wr_ack was low last cycle, write wr_data into back[wr_row] at the posedge and pulse wr_ack the next cycle. This gives a maximum of one write per 2 cycles.
  - Priority when several inputs are high in the same cycle: clear > commit > write.
  - clear goes to CLEAR. Any commit in that cycle is dropped and the write is not accepted.
  - commit goes to WAIT_SWAP. A write pending in the same cycle is not accepted; the writer must re-present it after busy falls.
- CLEAR:
  - A 4-bit index zeroes back[0..15], one row per cycle (16 cycles), then returns to IDLE.
  - clear or commit arriving during CLEAR is ignored.
- WAIT_SWAP:
  - Waits for frame_start. On that cycle front_sel toggles, and disp_frame reflects the new front from the next cycle.
  - Then goes to COPY.
  - If frame_start coincides with commit entry, the swap waits for the next frame_start; the commit cycle only enters the state.
- COPY:
  - Copies the new front buffer into the new back buffer, one row per cycle (16 cycles), then returns to IDLE.
  - This lets the renderer apply incremental updates to the just-displayed frame.
- busy is combinational from state (state != IDLE). wr_ack is never asserted while busy.
- disp_frame is registered and muxed from front_sel. It changes only on the cycle after a swap.
- Reset asserted mid-CLEAR, WAIT_SWAP or COPY aborts immediately to the reset state above; partially cleared or copied rows are zeroed by reset.
- clear/commit pulses longer than one cycle are each treated as a new request every cycle they are high in an accepting state.

Decomposition:
- Package led_pkg holds:
  - Localparams ROWS=16, COLS=16 and ROW_IDX_W=4.
  - Enum fsm_state_t {IDLE, CLEAR, WAIT_SWAP, COPY}.
  - Function row_slice(k) returning the disp_frame bit offset.
- One sub-module, led_scan_timer, contains:
  - The prescaler, scan_row, scan_tick and frame_start.
  - Parameter SCAN_DIV.
- The buffers, FSM and handshake stay in led_frame_ctrl.

Test Plan:
1. Reset then idle with SCAN_DIV=4 -> scan_tick every 4th cycle; scan_row 0..15 then 0; frame_start once per 64 cycles; disp_frame==0.
2. Write row 3=16'hA5A5, then commit -> wr_ack 1 cycle after req; busy high until frame_start+16 cycles; after the swap, disp_frame[63:48]==16'hA5A5 and all other rows zero.
3. After test 2, write row 3=16'h0001, then commit -> the back buffer was pre-copied; the new frame shows row3=16'h0001, and rows written earlier persist.
4. clear and commit in the same cycle with back row 5=16'hFFFF -> CLEAR for 16 cycles, no swap occurs, disp_frame unchanged; a later commit shows row5==0.
5. wr_req held high during WAIT_SWAP -> wr_ack stays 0 until busy falls, then it is acked exactly once and the data lands in the new back buffer.
6. rst_n low for 1 cycle mid-COPY (row 7) -> the next cycle has state IDLE, busy=0, disp_frame=0, scan_row=0, and the prescaler restarts at 0.
